// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit unsigned multiply / divide unit with a
// register-file write-back port.
// The FSM runs IDLE -> RUN (32 cycles) -> WB (1 cycle) -> IDLE, so the
// latency is fixed at 33 cycles from the accepting edge.
// Optional feature macro: MULDIV_DIV_EN compiles in the restoring divider
// for DIVU/REMU. Without it those ops still take the normal RUN/WB timing
// and write back 0.
module muldiv_unit (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   input  logic [4:0]  dest_reg,
   output logic        busy,
   output logic        write_enable,
   output logic [4:0]  write_reg,
   output logic [31:0] write_data
);

   typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

   state_t      state_reg, state_next;
   logic [5:0]  count_reg;
   logic [1:0]  op_reg;
   logic [4:0]  dest_hold_reg;
   logic [31:0] b_reg;
   // hi/lo hold {accumulator, multiplier} for multiply and
   // {remainder, dividend/quotient} for divide.
   logic [31:0] hi_reg, lo_reg;
   logic [31:0] hi_next, lo_next;
   logic [32:0] add_sum;
   logic [31:0] result;

`ifdef MULDIV_DIV_EN
   logic [32:0] shifted;
   logic [32:0] diff;
`endif

   // Next-state logic: RUN lasts while the counter walks 0..31.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (count_reg == 6'd31) state_next = WB;
         WB:      state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // One datapath step: shift-add for multiply, restoring shift-subtract for divide.
   always_comb begin
      add_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : 33'd0);
      hi_next = add_sum[32:1];
      lo_next = {add_sum[0], lo_reg[31:1]};
`ifdef MULDIV_DIV_EN
      // Remainder stays below the divisor, so bit 32 of diff is a clean borrow.
      // A zero divisor never borrows: quotient fills with ones, remainder becomes a.
      shifted = {hi_reg, lo_reg[31]};
      diff    = shifted - {1'b0, b_reg};
      if (op_reg[1]) begin
         if (!diff[32]) begin
            hi_next = diff[31:0];
            lo_next = {lo_reg[30:0], 1'b1};
         end else begin
            hi_next = shifted[31:0];
            lo_next = {lo_reg[30:0], 1'b0};
         end
      end
`endif
   end

   // Result selection from the finished hi/lo pair.
   always_comb begin
      result = 32'd0;
      case (op_reg)
         2'b00: result = lo_reg;
         2'b01: result = hi_reg;
`ifdef MULDIV_DIV_EN
         2'b10: result = lo_reg;
         2'b11: result = hi_reg;
`else
         2'b10: result = 32'd0;
         2'b11: result = 32'd0;
`endif
         default: result = 32'd0;
      endcase
   end

   // State register plus operand latching and iteration; start is only seen in IDLE.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= IDLE;
         count_reg     <= 6'd0;
         op_reg        <= 2'b00;
         dest_hold_reg <= 5'd0;
         b_reg         <= 32'd0;
         hi_reg        <= 32'd0;
         lo_reg        <= 32'd0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  op_reg        <= op;
                  dest_hold_reg <= dest_reg;
                  b_reg         <= operand_b;
                  hi_reg        <= 32'd0;
                  lo_reg        <= operand_a;
                  count_reg     <= 6'd0;
               end
            end
            RUN: begin
               hi_reg    <= hi_next;
               lo_reg    <= lo_next;
               count_reg <= count_reg + 6'd1;
            end
            WB: begin
               count_reg <= 6'd0;
            end
            default: count_reg <= 6'd0;
         endcase
      end
   end

   // Write-back port is driven only in WB; register 0 is never written.
   always_comb begin
      busy         = (state_reg != IDLE);
      write_enable = (state_reg == WB) && (dest_hold_reg != 5'd0);
      write_reg    = (state_reg == WB) ? dest_hold_reg : 5'd0;
      write_data   = (state_reg == WB) ? result : 32'd0;
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven checks of muldiv_unit plus hand-written
// sequences for start-while-busy and reset-mid-operation.
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] operand_a = 32'd0;
   logic [31:0] operand_b = 32'd0;
   logic [4:0]  dest_reg = 5'd0;
   logic        busy;
   logic        write_enable;
   logic [4:0]  write_reg;
   logic [31:0] write_data;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] rf [32];

   muldiv_unit dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .op           (op),
      .operand_a    (operand_a),
      .operand_b    (operand_b),
      .dest_reg     (dest_reg),
      .busy         (busy),
      .write_enable (write_enable),
      .write_reg    (write_reg),
      .write_data   (write_data)
   );

   always #5 clock = ~clock;

   // Register file fed by the write port; no special case for x0 here so
   // any stray write to register 0 becomes visible.
   always @(posedge clock) begin
      if (write_enable) rf[write_reg] <= write_data;
   end

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  dest;
      int          inject;
      logic        exp_we;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one operation (inputs set at a negedge), scramble inputs after
   // acceptance, then check all 33 busy cycles and the following IDLE cycle.
   task automatic run_op(input int idx, input vec_t v);
      int stray;
      op        = v.op;
      operand_a = v.a;
      operand_b = v.b;
      dest_reg  = v.dest;
      start     = 1'b1;
      @(posedge clock);
      #1;
      start     = 1'b0;
      op        = ~v.op;
      operand_a = ~v.a;
      operand_b = v.b ^ 32'h5A5A_1234;
      dest_reg  = ~v.dest;
      stray     = 0;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clock);
         chk($sformatf("v%0d busy c%0d", idx, k), {31'd0, busy}, 32'd1);
         if (k == v.inject) begin
            start     = 1'b1;
            op        = 2'b00;
            operand_a = 32'd1;
            operand_b = 32'd1;
            dest_reg  = 5'd9;
         end
         if (k == v.inject + 1) start = 1'b0;
         if (k < 33) begin
            if (write_enable || write_reg != 5'd0 || write_data != 32'd0) stray++;
         end else begin
            chk($sformatf("v%0d write_enable", idx), {31'd0, write_enable}, {31'd0, v.exp_we});
            chk($sformatf("v%0d write_reg", idx), {27'd0, write_reg}, {27'd0, v.dest});
            chk($sformatf("v%0d write_data", idx), write_data, v.exp_data);
         end
      end
      start = 1'b0;
      @(negedge clock);
      chk($sformatf("v%0d idle busy", idx), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d idle write_enable", idx), {31'd0, write_enable}, 32'd0);
      chk($sformatf("v%0d early outputs", idx), stray, 32'd0);
   endtask

   initial begin
      int pulses;
      vec_t v;
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;

      vecs[0]  = '{2'b00, 32'h0001_0003, 32'h0000_0005, 5'd1,  0,  1'b1, 32'h0005_000F};
      vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  10, 1'b1, 32'hFFFF_FFFE};
      vecs[2]  = '{2'b10, 32'd100,       32'd7,         5'd3,  0,  1'b1, DIV_EN ? 32'd14 : 32'd0};
      vecs[3]  = '{2'b11, 32'd100,       32'd7,         5'd4,  0,  1'b1, DIV_EN ? 32'd2 : 32'd0};
      vecs[4]  = '{2'b10, 32'hDEAD_BEEF, 32'd0,         5'd8,  0,  1'b1, DIV_EN ? 32'hFFFF_FFFF : 32'd0};
      vecs[5]  = '{2'b11, 32'hDEAD_BEEF, 32'd0,         5'd10, 0,  1'b1, DIV_EN ? 32'hDEAD_BEEF : 32'd0};
      vecs[6]  = '{2'b00, 32'd6,         32'd7,         5'd0,  0,  1'b0, 32'd42};
      vecs[7]  = '{2'b10, 32'd100,       32'd7,         5'd6,  0,  1'b1, DIV_EN ? 32'd14 : 32'd0};
      vecs[8]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 0,  1'b1, 32'h0000_0001};
      vecs[9]  = '{2'b01, 32'h8000_0000, 32'd4,         5'd12, 0,  1'b1, 32'h0000_0002};
      vecs[10] = '{2'b11, 32'hFFFF_FFFF, 32'd10,        5'd13, 0,  1'b1, DIV_EN ? 32'd5 : 32'd0};
      vecs[11] = '{2'b10, 32'd5,         32'd9,         5'd14, 0,  1'b1, 32'd0};
      vecs[12] = '{2'b11, 32'd5,         32'd9,         5'd15, 0,  1'b1, DIV_EN ? 32'd5 : 32'd0};

      // Reset state, with start held high to show reset wins.
      start = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset write_enable", {31'd0, write_enable}, 32'd0);
      chk("reset write_reg", {27'd0, write_reg}, 32'd0);
      chk("reset write_data", write_data, 32'd0);
      start = 1'b0;
      reset = 1'b0;
      @(negedge clock);

      // Back-to-back table run: each op starts in the first IDLE cycle of the previous.
      for (int i = 0; i < 13; i++) begin
         run_op(i, vecs[i]);
         $display("vec %0d op=%0d a=%h b=%h dest=%0d -> we=%0b data=%h", i, vecs[i].op,
                  vecs[i].a, vecs[i].b, vecs[i].dest, vecs[i].exp_we, vecs[i].exp_data);
      end

      // Reset during RUN cycle 10 aborts without a write.
      op = 2'b00; operand_a = 32'd6; operand_b = 32'd7; dest_reg = 5'd7;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      for (int k = 1; k <= 10; k++) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort write_enable", {31'd0, write_enable}, 32'd0);
      reset = 1'b0;
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (write_enable || busy) pulses++;
      end
      chk("abort quiet", pulses, 32'd0);
      $display("reset abort at RUN cycle 10 -> no write");

      v = '{2'b00, 32'd2, 32'd3, 5'd5, 0, 1'b1, 32'd6};
      run_op(13, v);
      $display("post-reset MUL 2x3 -> reg5");

      @(negedge clock);
      chk("rf x0", rf[0], 32'd0);
      chk("rf x1", rf[1], 32'h0005_000F);
      chk("rf x2", rf[2], 32'hFFFF_FFFE);
      chk("rf x5", rf[5], 32'd6);
      chk("rf x7", rf[7], 32'd0);
      chk("rf x9", rf[9], 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
